// File: rtl/cache.sv
// Direct-mapped, one-word-per-line, write-through / no-allocate cache in front
// of a word-addressed backing memory, with a valid/ready request and response handshake.
module cache #(
    parameter int MEM_WORDS    = 1024,
    parameter int LINES        = 16,
    parameter int MISS_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] addr_in,
    input  logic        op_in,
    input  logic [31:0] write_data_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] data_out
);

    localparam int WORD_W = $clog2(MEM_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = WORD_W - IDX_W;
    localparam int CNT_W  = $clog2(MISS_LATENCY);
    // The acceptance edge counts as the first of the MISS_LATENCY edges,
    // and the edge that sees zero moves to RESP.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MISS_LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic [31:0]       data_q,  data_d;

    logic [31:0]       mem_q [MEM_WORDS] = '{default: '0};
    logic [LINES-1:0]  line_valid_q;
    logic [TAG_W-1:0]  line_tag_q  [LINES];
    logic [31:0]       line_data_q [LINES];

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              req_hit;
    logic              mem_we;
    logic              line_wr;
    logic              line_fill;
    logic              unused_addr_bits;

    // Upper address bits alias onto the same memory word.
    assign req_word = addr_in[WORD_W+1:2];
    assign req_idx  = req_word[IDX_W-1:0];
    assign req_tag  = req_word[WORD_W-1:IDX_W];
    assign fill_idx = word_q[IDX_W-1:0];
    assign fill_tag = word_q[WORD_W-1:IDX_W];
    assign req_hit  = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);

    assign unused_addr_bits = ^{addr_in[31:WORD_W+2], addr_in[1:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        word_d    = word_q;
        data_d    = data_q;
        mem_we    = 1'b0;
        line_wr   = 1'b0;
        line_fill = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    word_d = req_word;
                    if (op_in) begin
                        mem_we  = 1'b1;
                        line_wr = req_hit;
                        data_d  = write_data_in;
                        state_d = RESP;
                    end else if (req_hit) begin
                        data_d  = line_data_q[req_idx];
                        state_d = RESP;
                    end else begin
                        count_d = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count_q == '0) begin
                    line_fill = 1'b1;
                    data_d    = mem_q[word_q];
                    state_d   = RESP;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (ready_out) begin
                    data_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_q       <= '0;
            data_q       <= '0;
            line_valid_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            data_q  <= data_d;
            if (line_fill) begin
                line_valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // NOTE: storage arrays carry no reset; the line valid bits alone make their contents meaningful.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[req_word] <= write_data_in;
        end
        if (line_wr) begin
            line_data_q[req_idx] <= write_data_in;
        end else if (line_fill) begin
            line_tag_q[fill_idx]  <= fill_tag;
            line_data_q[fill_idx] <= mem_q[word_q];
        end
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = (state_q == RESP);
    assign data_out  = valid_out ? data_q : '0;

endmodule

// File: tb/tb_cache.sv
// Directed self-checking bench for the cache: reset, miss/hit latency, write-through,
// conflict eviction, backpressure, address wrap-around and reset during a miss.
module tb_cache;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] addr_in;
    logic        op_in;
    logic [31:0] write_data_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;

    int n_checks;
    int n_fails;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
    localparam int   LAT_HIT  = 1;
    localparam int   LAT_MISS = 4;

    cache #(
        .MEM_WORDS   (1024),
        .LINES       (16),
        .MISS_LATENCY(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .addr_in      (addr_in),
        .op_in        (op_in),
        .write_data_in(write_data_in),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request from a negedge; returns the number of rising edges from
    // acceptance (inclusive) until valid_out is seen, and the response data.
    task automatic issue(input logic op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data);
        valid_in      = 1'b1;
        op_in         = op;
        addr_in       = addr;
        write_data_in = wd;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!valid_out && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        data = data_out;
    endtask

    task automatic access(input string tag, input logic op, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_data);
        int          lat;
        logic [31:0] d;
        issue(op, addr, wd, lat, d);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, d, exp_data);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_back_idle"}, {valid_out, ready_in}, 32'b01);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, "_ready_in"}, ready_in, 1'b1);
        check({tag, "_valid_out"}, valid_out, 1'b0);
        check({tag, "_data_out"}, data_out, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] d0;
        int          lat;
        logic [31:0] d;

        n_checks      = 0;
        n_fails       = 0;
        reset         = 1'b0;
        valid_in      = 1'b0;
        op_in         = OP_RD;
        addr_in       = '0;
        write_data_in = '0;
        ready_out     = 1'b1;

        #3;
        check("rst_ready_in", ready_in, 1'b1);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_out", data_out, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        access("first_rd", OP_RD, 32'h10, 32'h0, LAT_MISS, 32'h0);

        apply_reset("rst2");
        access("wr_10", OP_WR, 32'h10, 32'hDEAD_BEEF, LAT_HIT, 32'hDEAD_BEEF);
        access("rd_10_miss", OP_RD, 32'h10, 32'h0, LAT_MISS, 32'hDEAD_BEEF);
        access("rd_10_hit", OP_RD, 32'h10, 32'h0, LAT_HIT, 32'hDEAD_BEEF);

        access("wr_50", OP_WR, 32'h50, 32'h1234_5678, LAT_HIT, 32'h1234_5678);
        access("rd_50_miss", OP_RD, 32'h50, 32'h0, LAT_MISS, 32'h1234_5678);
        access("rd_10_evict", OP_RD, 32'h10, 32'h0, LAT_MISS, 32'hDEAD_BEEF);

        // Backpressure on a hit; a write to 0x20 pulsed meanwhile must be dropped.
        ready_out = 1'b0;
        issue(OP_RD, 32'h10, 32'h0, lat, d0);
        check("bp_lat", lat, LAT_HIT);
        check("bp_data0", d0, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                valid_in      = 1'b1;
                op_in         = OP_WR;
                addr_in       = 32'h20;
                write_data_in = 32'h0000_0BAD;
            end
            @(posedge clk);
            @(negedge clk);
            valid_in = 1'b0;
            check("bp_valid_out", valid_out, 1'b1);
            check("bp_data_out", data_out, 32'hDEAD_BEEF);
            check("bp_ready_in", ready_in, 1'b0);
        end
        ready_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", {valid_out, ready_in}, 32'b01);
        check("bp_release_data", data_out, 32'h0);
        access("rd_20_ignored", OP_RD, 32'h20, 32'h0, LAT_MISS, 32'h0);

        access("wr_1010", OP_WR, 32'h1010, 32'hA5A5_A5A5, LAT_HIT, 32'hA5A5_A5A5);
        access("rd_10_wrap", OP_RD, 32'h10, 32'h0, LAT_HIT, 32'hA5A5_A5A5);

        // Reset two cycles into a read miss of 0x30.
        access("wr_30", OP_WR, 32'h30, 32'h0BAD_F00D, LAT_HIT, 32'h0BAD_F00D);
        valid_in = 1'b1;
        op_in    = OP_RD;
        addr_in  = 32'h30;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_wait_state", {valid_out, ready_in}, 32'b00);
        reset = 1'b0;
        #1;
        check("mid_rst_ready_in", ready_in, 1'b1);
        check("mid_rst_valid_out", valid_out, 1'b0);
        check("mid_rst_data_out", data_out, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_resp", valid_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        access("rd_30_after_rst", OP_RD, 32'h30, 32'h0, LAT_MISS, 32'h0BAD_F00D);
        access("rd_10_after_rst", OP_RD, 32'h10, 32'h0, LAT_MISS, 32'hA5A5_A5A5);

        issue(OP_RD, 32'h30, 32'h0, lat, d);
        check("rd_30_hit_lat", lat, LAT_HIT);
        check("rd_30_hit_data", d, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
